// File: rtl/execute_mc.sv
// execute_mc: LEGv8 execute stage with ALU, branch adder and iterative multi-cycle MUL
module execute_mc #(
  parameter int N = 64,
  parameter int MUL_STEP = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         AluSrc,
  input  logic [3:0]   AluControl,
  input  logic         MulOp,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] signImm_E,
  input  logic [N-1:0] readData1_E,
  input  logic [N-1:0] readData2_E,
  output logic [N-1:0] PCBranch_E,
  output logic [N-1:0] aluResult_E,
  output logic [N-1:0] writeData_E,
  output logic         zero_E,
  output logic         stall_E,
  output logic         done_E
);
  localparam int STEPS = N / MUL_STEP;
  localparam int CW = $clog2(STEPS) + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [N-1:0] b, alu, acc, mcand, mplier;
  logic [CW-1:0] cnt;
  logic start;
  assign b = AluSrc ? signImm_E : readData2_E;
  assign start = valid_E && MulOp && state == IDLE;
  assign PCBranch_E = PC_E + (signImm_E << 2);
  assign writeData_E = readData2_E;
  always_comb begin
    alu = AluControl == 4'b0000 ? readData1_E & b :
          AluControl == 4'b0001 ? readData1_E | b :
          AluControl == 4'b0010 ? readData1_E + b :
          AluControl == 4'b0110 ? readData1_E - b :
          AluControl == 4'b0111 ? b :
          AluControl == 4'b1100 ? ~(readData1_E | b) : '0;
  end
  // a MUL opcode, bubble or not, never exposes the ALU result
  assign aluResult_E = state == DONE ? acc : (state == BUSY || MulOp) ? '0 : alu;
  assign zero_E = aluResult_E == '0;
  assign stall_E = reset && (state == BUSY || start);
  assign done_E = state == DONE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
    end else if (start) begin
      state <= BUSY;
      acc <= '0;
      mcand <= readData1_E;
      mplier <= b;
      cnt <= '0;
    end else if (state == BUSY) begin
      acc <= acc + mcand * N'(mplier[MUL_STEP-1:0]);
      mcand <= mcand << MUL_STEP;
      mplier <= mplier >> MUL_STEP;
      cnt <= cnt + 1'b1;
      state <= cnt == CW'(STEPS - 1) ? DONE : BUSY;
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_execute_mc.sv
// tb_execute_mc: directed and random checks of execute_mc against an arithmetic reference model
module tb_execute_mc;
  localparam int N = 64;
  logic clk = 0, reset = 1, valid1 = 0, valid4 = 0, alu_src = 0, mul_op = 0;
  logic [3:0] alu_ctrl = 4'b0000;
  logic [N-1:0] pc = '0, imm = '0, rd1 = '0, rd2 = '0;
  logic [N-1:0] pcb1, res1, wd1, pcb4, res4, wd4;
  logic z1, st1, dn1, z4, st4, dn4;
  int checks = 0, failures = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(negedge clk) cyc++;
  execute_mc #(.N(N), .MUL_STEP(1)) dut1 (
    .clk(clk), .reset(reset), .valid_E(valid1), .AluSrc(alu_src), .AluControl(alu_ctrl),
    .MulOp(mul_op), .PC_E(pc), .signImm_E(imm), .readData1_E(rd1), .readData2_E(rd2),
    .PCBranch_E(pcb1), .aluResult_E(res1), .writeData_E(wd1), .zero_E(z1), .stall_E(st1), .done_E(dn1));
  execute_mc #(.N(N), .MUL_STEP(4)) dut4 (
    .clk(clk), .reset(reset), .valid_E(valid4), .AluSrc(alu_src), .AluControl(alu_ctrl),
    .MulOp(mul_op), .PC_E(pc), .signImm_E(imm), .readData1_E(rd1), .readData2_E(rd2),
    .PCBranch_E(pcb4), .aluResult_E(res4), .writeData_E(wd4), .zero_E(z4), .stall_E(st4), .done_E(dn4));

  function automatic logic [N-1:0] model_alu(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] bb);
    case (op)
      4'b0000: return a & bb;
      4'b0001: return a | bb;
      4'b0010: return a + bb;
      4'b0110: return a - bb;
      4'b0111: return bb;
      4'b1100: return ~(a | bb);
      default: return '0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rnd64(output logic [N-1:0] v);
    v = {$urandom, $urandom};
  endtask

  // starts a MUL on one instance, follows it to done and checks latency, stall length and product
  task automatic run_mul(input bit four, input logic [N-1:0] a, input logic [N-1:0] bv, input bit use_imm,
                         input bit keep, output int t0, output int done_at);
    int lat, stalls;
    logic [N-1:0] exp, r;
    logic st, dn, z;
    lat = four ? N / 4 : N;
    exp = a * bv;
    @(negedge clk);
    valid1 = !four; valid4 = four; mul_op = 1; alu_src = use_imm; rd1 = a;
    if (use_imm) imm = bv; else rd2 = bv;
    #1;
    t0 = cyc; stalls = 0; done_at = -1;
    r = '0; st = 0; z = 0;
    for (int i = 0; i < 200; i++) begin
      st = four ? st4 : st1; dn = four ? dn4 : dn1; r = four ? res4 : res1; z = four ? z4 : z1;
      if (dn) begin
        done_at = cyc;
        break;
      end
      if (st) stalls++;
      if (i == 3) check("mul_busy_result", r, '0);
      @(negedge clk);
      rnd64(rd1); rnd64(rd2); rnd64(imm);
      #1;
    end
    check("mul_latency", 64'(done_at - t0), 64'(lat + 1));
    check("mul_stall_cycles", 64'(stalls), 64'(lat + 1));
    check("mul_result", r, exp);
    check("mul_zero", 64'(z), 64'(exp == '0));
    check("mul_stall_at_done", 64'(st), 64'(0));
    if (!keep) begin
      @(negedge clk);
      valid1 = 0; valid4 = 0; mul_op = 0;
      #1;
      check("mul_single_pulse", 64'(four ? dn4 : dn1), 64'(0));
    end
  endtask

  initial begin
    int t0, d1, d2, pulses;
    logic [3:0] codes [8];
    logic [N-1:0] a, bb, bsel, exp;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011, 4'b1111};
    #2 reset = 0;
    @(negedge clk); #1;
    check("reset_stall", 64'(st1), 64'(0));
    check("reset_done", 64'(dn1), 64'(0));
    @(negedge clk); reset = 1;
    valid1 = 1; alu_src = 0; alu_ctrl = 4'b0010; rd1 = 5; rd2 = 7; #1;
    check("add_result", res1, 64'd12);
    check("add_zero", 64'(z1), 64'(0));
    check("add_stall", 64'(st1), 64'(0));
    @(negedge clk); alu_ctrl = 4'b0110; rd1 = 7; rd2 = 7; #1;
    check("sub_result", res1, 64'd0);
    check("sub_zero", 64'(z1), 64'(1));
    pc = 64'h100; imm = 64'd4; #1;
    check("branch_pos", pcb1, 64'h110);
    imm = '1; #1;
    check("branch_neg", pcb1, 64'hFC);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      valid1 = 1'($urandom_range(0, 1)); mul_op = 0; alu_src = 1'($urandom_range(0, 1));
      alu_ctrl = codes[$urandom_range(0, 7)];
      rnd64(rd1); rnd64(rd2); rnd64(imm); rnd64(pc);
      if (i % 5 == 0) rd2 = rd1;
      #1;
      bsel = alu_src ? imm : rd2;
      exp = model_alu(alu_ctrl, rd1, bsel);
      check("rand_alu", res1, exp);
      check("rand_zero", 64'(z1), 64'(exp == '0));
      check("rand_branch", pcb1, pc + imm * 4);
      check("rand_wdata", wd1, rd2);
      check("rand_no_stall", 64'(st1 | dn1), 64'(0));
    end
    @(negedge clk); valid1 = 0; mul_op = 1; alu_ctrl = 4'b0010; rd1 = 3; rd2 = 4; alu_src = 0; #1;
    check("bubble_stall", 64'(st1), 64'(0));
    check("bubble_result", res1, '0);
    @(negedge clk); #1;
    check("bubble_no_start", 64'(st1 | dn1), 64'(0));
    mul_op = 0;
    run_mul(0, 64'd3, 64'd5, 0, 0, t0, d1);
    run_mul(1, 64'd3, 64'd5, 0, 0, t0, d1);
    run_mul(0, '1, 64'd2, 1, 0, t0, d1);
    run_mul(1, '1, 64'd2, 1, 0, t0, d1);
    run_mul(0, 64'd0, 64'd9, 0, 0, t0, d1);
    for (int i = 0; i < 3; i++) begin
      rnd64(a); rnd64(bb);
      run_mul(1'(i % 2), a, bb, 1'(i == 2), 0, t0, d1);
    end
    @(negedge clk); valid1 = 1; mul_op = 1; alu_src = 0; rd1 = 64'd11; rd2 = 64'd13;
    repeat (10) @(negedge clk);
    reset = 0; #1;
    check("midmul_reset_stall", 64'(st1), 64'(0));
    check("midmul_reset_done", 64'(dn1), 64'(0));
    @(negedge clk); valid1 = 0; mul_op = 0;
    @(negedge clk); reset = 1;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk); #1;
      if (dn1 || st1) pulses++;
    end
    check("no_done_after_reset", 64'(pulses), 64'(0));
    run_mul(0, 64'd6, 64'd7, 0, 0, t0, d1);
    run_mul(0, 64'd2, 64'd3, 0, 1, t0, d1);
    run_mul(0, 64'd4, 64'd5, 0, 0, d2, d2);
    check("b2b_first_done", 64'(d1 - t0), 64'd65);
    check("b2b_second_done", 64'(d2 - t0), 64'd131);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
